i2c_write_master: RTL
=====================

# i2c_write_master

Single-transaction I2C write master that drives the SGTL5000 codec control port. It sits between the codec configuration sequencer and the board's I2C_SCL/I2C_SDA pins. On each `interface_enable` pulse it writes one 16-bit register address and one 16-bit data word to the codec. It reports completion back to the sequencer through the level handshake `interface_acknowledge`.

## Interface
- `CLK_DIV`, 125, clk50 cycles per quarter SCL period; must be ≥ 4. The default gives 100 kHz SCL.
- `DEV_ADDR`, 7'h0A, 7-bit codec slave address. The transmitted first byte is {DEV_ADDR, 1'b0}, which is 0x14.
- `clk50` in 1: system clock, 50 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `i2c_address` in 16: codec register address. Sampled only on an accepted enable.
- `i2c_data` in 16: register write data. Sampled only on an accepted enable.
- `interface_enable` in 1: one-cycle request pulse from the sequencer.
- `interface_acknowledge` out 1: high means idle and ready; low means a transaction is in progress.
- `nack_error` out 1: sticky flag, set when any byte is NACKed. Cleared only by reset.
- `I2C_SCL` inout 1: open-drain clock. The block drives 0 or Z; it never drives 1.
- `I2C_SDA` inout 1: open-drain data. The block drives 0 or Z; SDA is read back through a 2-flop synchronizer.

## Operation
- States: IDLE, START, BYTE, ACK, STOP, BUF.
- Quarter tick: a prescaler asserts a one-cycle tick every CLK_DIV cycles. It restarts at 0 on transaction acceptance. All bus phase changes occur on ticks.
- IDLE:
  - SCL and SDA are released (Z) and `interface_acknowledge`=1.
  - `interface_enable`=1 is accepted: the block latches {DEV byte, addr[15:8], addr[7:0], data[15:8], data[7:0]} into a 5-byte shift source, drives `interface_acknowledge`=0 on the next edge, and enters START.
- START (4 quarters): SCL Z with SDA Z, then SDA 0, then SCL 0.
- BYTE: 8 bits, MSB first, 4 quarters per bit:
  - q0: SCL 0, SDA set to the bit (0 → drive 0, 1 → Z).
  - q1: SCL 0.
  - q2: SCL Z.
  - q3: SCL Z.
- ACK (4 quarters): SDA is released. The synchronized SDA is sampled at q3.
  - 0 = ACK: go to the next byte, or to STOP after byte 4.
  - 1 = NACK: set `nack_error` and go directly to STOP.
- STOP (4 quarters): SCL 0 with SDA 0, then SCL Z, then SDA Z.
- BUF: 4 quarters of bus-free time, then `interface_acknowledge`=1 and return to IDLE.
- The block does not support clock stretching or arbitration and never samples SCL.
- `interface_enable` is ignored in every state except IDLE.
- The block always returns `interface_acknowledge` high after a NACK, so the sequencer still advances.
- `interface_acknowledge` is registered and glitch-free. The sequencer counts its falling edge as the advance to the next register.

## Timing
- Reset values: `interface_acknowledge`=0, `nack_error`=0, SCL=Z, SDA=Z, state=IDLE.
- After reset release, the first clk50 edge sets `interface_acknowledge`=1. This provides the rising edge the sequencer needs to issue its first request.
- With enable sampled at edge E:
  - `interface_acknowledge` falls at E+1.
  - The first SDA fall (START) occurs at E+1+CLK_DIV.
- Full ACKed transaction: 4 + 5×36 + 4 + 4 = 192 quarters. `interface_acknowledge` rises at E+1+192×CLK_DIV, which is E+24001 at the default.
- NACK on byte k (0..4): `interface_acknowledge` rises at E+1+(4+36×(k+1)+8)×CLK_DIV.
- SDA changes only while SCL is driven 0, except for the START and STOP edges.
- Enable pulses arriving in the same cycle as the rise of `interface_acknowledge` are ignored. An enable is accepted only when `interface_acknowledge` is already 1.
- Reset asserted mid-transaction immediately releases both lines and returns all outputs to their reset values. No bus-recovery clocks are generated.

## Test plan
- Reset/idle: hold reset_n=0, then release it → SCL=Z and SDA=Z throughout, `nack_error`=0, `interface_acknowledge` 0 → 1 on the first edge after release.
- Single write: address 0x0032, data 0x739B, responder ACKs every byte → decoded bytes 0x14, 0x00, 0x32, 0x73, 0x9B, then a STOP. `interface_acknowledge` falls at E+1 and rises at E+24001. `nack_error`=0.
- NACK on the device byte → `nack_error`=1 after the 9th SCL pulse, STOP follows immediately, `interface_acknowledge` rises at E+1+48×125, and no further bytes appear.
- Enable pulses at E+10 and E+5000 during a transaction → ignored; exactly one transaction appears on the bus.
- Assert reset_n=0 during byte 2 → SCL and SDA become Z within the same cycle, `interface_acknowledge`=0, and `nack_error`=0. After release, a new write completes correctly.
- Connected to the codec configuration sequencer with an always-ACK responder → 11 writes in order: 0x0000/0x0000, 0x0032/0x739B, 0x0030/0x45FE, 0x0028/0x004E, 0x0002/0x0063, 0x0004/0x0007, 0x0006/0x00B0, 0x0024/0x0004, 0x000A/0x0010, 0x000E/0x0000, 0x0014/0x555F. After the last write the bus stays idle.

Source files
------------

// File: rtl/i2c_write_master_if.sv
// Control-side bundle between the codec configuration sequencer (master)
// and the I2C write engine (slave).
interface i2c_write_master_if;
  // Level handshake: the slave holds interface_acknowledge high while idle.
  // The master may pulse interface_enable for one cycle only while it is high.
  // The slave drops interface_acknowledge on the edge after accepting and
  // raises it again when the bus write has finished, whether ACKed or not.
  logic [15:0] i2c_address;
  logic [15:0] i2c_data;
  logic        interface_enable;
  logic        interface_acknowledge;
  logic        nack_error;

  modport master (
    output i2c_address,
    output i2c_data,
    output interface_enable,
    input  interface_acknowledge,
    input  nack_error
  );

  modport slave (
    input  i2c_address,
    input  i2c_data,
    input  interface_enable,
    output interface_acknowledge,
    output nack_error
  );
endinterface

// File: rtl/i2c_write_master.sv
// Single-transaction I2C write master: START, device byte, two address
// bytes, two data bytes, STOP, then a bus-free gap before signalling idle.
module i2c_write_master #(
  parameter int         CLK_DIV  = 125,
  parameter logic [6:0] DEV_ADDR = 7'h0A
) (
  input  logic              clk50,
  input  logic              reset_n,
  i2c_write_master_if.slave ctrl,
  inout  wire               I2C_SCL,
  inout  wire               I2C_SDA,
  output logic [2:0]        state_dbg
);

  localparam int            PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP, BUF} state_t;

  state_t        state, state_n;
  logic [1:0]    quarter, quarter_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [2:0]    byte_cnt, byte_n;
  logic [39:0]   shift, shift_n;
  logic          nack_q, nack_n;
  logic          ack_q, ack_n;
  logic          scl_low, scl_low_n;
  logic          sda_low, sda_low_n;
  logic [PW-1:0] pre_cnt;
  logic          sda_meta, sda_sync;
  logic          tick;
  logic          accept;

  assign tick   = (pre_cnt == PRE_LAST);
  assign accept = (state == IDLE) && ack_q && ctrl.interface_enable;

  // Open-drain pins: only ever pull low or release.
  assign I2C_SCL = scl_low ? 1'b0 : 1'bz;
  assign I2C_SDA = sda_low ? 1'b0 : 1'bz;

  assign ctrl.interface_acknowledge = ack_q;
  assign ctrl.nack_error            = nack_q;
  assign state_dbg                  = state;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      quarter  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      nack_q   <= 1'b0;
      ack_q    <= 1'b0;
      scl_low  <= 1'b0;
      sda_low  <= 1'b0;
      pre_cnt  <= '0;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      state    <= state_n;
      quarter  <= quarter_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      shift    <= shift_n;
      nack_q   <= nack_n;
      ack_q    <= ack_n;
      scl_low  <= scl_low_n;
      sda_low  <= sda_low_n;
      sda_meta <= I2C_SDA;
      sda_sync <= sda_meta;
      pre_cnt  <= (accept || tick) ? '0 : pre_cnt + PW'(1);
    end
  end

  always_comb begin
    state_n   = state;
    quarter_n = quarter;
    bit_n     = bit_cnt;
    byte_n    = byte_cnt;
    shift_n   = shift;
    nack_n    = nack_q;
    // Acknowledge and pin drives are decoded from the current state and
    // registered, so they lag the state by one cycle and never glitch.
    ack_n     = (state == IDLE);
    scl_low_n = 1'b0;
    sda_low_n = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          shift_n   = {DEV_ADDR, 1'b0, ctrl.i2c_address, ctrl.i2c_data};
          quarter_n = 2'd0;
          bit_n     = 3'd0;
          byte_n    = 3'd0;
          state_n   = START;
        end
      end
      default: begin
        if (tick) begin
          quarter_n = quarter + 2'd1;
          if (quarter == 2'd3) begin
            case (state)
              START: state_n = BYTE;
              BYTE: begin
                shift_n = {shift[38:0], 1'b0};
                bit_n   = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_n = ACK;
              end
              ACK: begin
                if (sda_sync) begin
                  nack_n  = 1'b1;
                  state_n = STOP;
                end else if (byte_cnt == 3'd4) begin
                  state_n = STOP;
                end else begin
                  byte_n  = byte_cnt + 3'd1;
                  state_n = BYTE;
                end
              end
              STOP:    state_n = BUF;
              BUF:     state_n = IDLE;
              default: state_n = IDLE;
            endcase
          end
        end
      end
    endcase

    case (state)
      START: begin
        sda_low_n = (quarter != 2'd0);
        scl_low_n = (quarter >= 2'd2);
      end
      BYTE: begin
        scl_low_n = ~quarter[1];
        sda_low_n = ~shift[39];
      end
      ACK:  scl_low_n = ~quarter[1];
      STOP: begin
        scl_low_n = (quarter == 2'd0);
        sda_low_n = (quarter <= 2'd1);
      end
      default: ;
    endcase
  end

endmodule
